// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both requester ports and the RAM-side bus that the
// arbiter connects. The slave view belongs to the arbiter. The master view
// belongs to whatever drives requests and models the RAM.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-port, fixed-latency
// data RAM between the CPU port (0) and a second bus master (port 1).
//
// state | meaning
// IDLE  | no transaction; grants a waiting port, alternating on a tie
// ISSUE | one-cycle RAM strobe using the latched command
// WAIT  | read latency countdown; read data is captured on the count of 1
// DONE  | one-cycle ack to the owning port, then back to IDLE
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Only the low four bits are loaded. LATENCY above 15 is not supported.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t        state;
  logic          lat_we;
  logic [3:0]    wait_cnt;

  logic          grant_sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Winner selection: a lone requester wins. On a tie, the port that did not
  // own the last transaction wins.
  always_comb begin
    grant_sel = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      grant_sel = ~bus.owner;
    end
    sel_we    = grant_sel ? bus.m1_we    : bus.m0_we;
    sel_addr  = grant_sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = grant_sel ? bus.m1_wdata : bus.m0_wdata;
  end

  // Sequencer. All outputs are registered. The RAM address and write data
  // registers double as the latched command and hold their value between
  // transactions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      lat_we        <= 1'b0;
      wait_cnt      <= 4'd0;
      bus.owner     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state         <= S_ISSUE;
            bus.owner     <= grant_sel;
            lat_we        <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          if (lat_we) begin
            state <= S_DONE;
            if (bus.owner) bus.m1_ack <= 1'b1;
            else           bus.m0_ack <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_DONE;
            if (bus.owner) begin
              bus.m1_rdata <= bus.mem_rdata;
              bus.m1_ack   <= 1'b1;
            end else begin
              bus.m0_rdata <= bus.mem_rdata;
              bus.m0_ack   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (LATENCY 3, 1 and 4), each with a
// behavioural RAM. A transaction-level model predicts the outputs of the
// active instance on every cycle.
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][1:0]       req, we, ack;
  logic [2:0][1:0][31:0] addr, wdata, rdata;
  logic [2:0]            mem_en, mem_we, busy, owner;
  logic [2:0][31:0]      mem_addr, mem_wdata;
  int                    lat [3] = '{3, 1, 4};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 4;
    mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    logic [31:0] ram  [16];
    logic [31:0] pipe [16];

    mem_arbiter #(.AW(32), .DW(32), .LATENCY(L)) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
    );

    assign bus.m0_req   = req[g][0];
    assign bus.m0_we    = we[g][0];
    assign bus.m0_addr  = addr[g][0];
    assign bus.m0_wdata = wdata[g][0];
    assign bus.m1_req   = req[g][1];
    assign bus.m1_we    = we[g][1];
    assign bus.m1_addr  = addr[g][1];
    assign bus.m1_wdata = wdata[g][1];
    assign ack[g][0]    = bus.m0_ack;
    assign ack[g][1]    = bus.m1_ack;
    assign rdata[g][0]  = bus.m0_rdata;
    assign rdata[g][1]  = bus.m1_rdata;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;
    assign busy[g]      = bus.busy;
    assign owner[g]     = bus.owner;

    initial for (int k = 0; k < 16; k++) ram[k] = 32'hA5A5_0000 | 32'(k);

    // RAM: writes on the strobe edge, read data emerges L cycles after the strobe cycle
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[5:2]] : 32'h0BAD_F00D;
      for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[L-1];
  end

  // reference model state
  int                    errors = 0;
  int                    checks = 0;
  int                    cyc = 0;
  int                    g_cyc = 0;
  int                    a_cyc = 0;
  int                    en_count = 0;
  bit                    active = 1'b0;
  bit                    rnd_en = 1'b0;
  logic                  win, t_we;
  logic [31:0]           t_addr, t_data;
  logic [2:0]            mown;
  logic [2:0][1:0][31:0] exp_rdata;
  logic [2:0][31:0]      exp_maddr, exp_mwd;
  logic [31:0]           shadow [3][16];
  txn_t                  plan0 [$];
  txn_t                  plan1 [$];
  int                    grants [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load_port(input int i, input int p, input txn_t t);
    we[i][p]    = t.we;
    addr[i][p]  = t.addr;
    wdata[i][p] = t.data;
    req[i][p]   = 1'b1;
  endtask

  task automatic model_reset();
    active    = 1'b0;
    mown      = 3'b111;
    exp_rdata = '0;
    exp_maddr = '0;
    exp_mwd   = '0;
  endtask

  // One cycle of instance i: check outputs, then move the requesters and the model.
  task automatic step(input int i);
    bit   was_idle;
    txn_t t;
    @(negedge clk);
    cyc++;
    if (active && cyc == g_cyc + 1) begin
      mown[i]      = win;
      exp_maddr[i] = t_addr;
      exp_mwd[i]   = t_data;
    end
    if (active && cyc == a_cyc && !t_we) exp_rdata[i][win] = shadow[i][t_addr[5:2]];
    en_count += int'(mem_en[i]);

    chk("busy",      busy[i],      active && cyc > g_cyc);
    chk("mem_en",    mem_en[i],    active && cyc == g_cyc + 1);
    chk("mem_we",    mem_we[i],    active && cyc == g_cyc + 1 && t_we);
    chk("ack0",      ack[i][0],    active && cyc == a_cyc && win == 1'b0);
    chk("ack1",      ack[i][1],    active && cyc == a_cyc && win == 1'b1);
    chk("owner",     owner[i],     mown[i]);
    chk("rdata0",    rdata[i][0],  exp_rdata[i][0]);
    chk("rdata1",    rdata[i][1],  exp_rdata[i][1]);
    chk("mem_addr",  mem_addr[i],  exp_maddr[i]);
    chk("mem_wdata", mem_wdata[i], exp_mwd[i]);

    was_idle = !active;
    if (active && cyc == a_cyc) begin
      active       = 1'b0;
      req[i][win]  = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!req[i][p]) begin
          if (p == 0 && plan0.size() > 0) begin
            t = plan0.pop_front();
            load_port(i, p, t);
          end else if (p == 1 && plan1.size() > 0) begin
            t = plan1.pop_front();
            load_port(i, p, t);
          end else if (rnd_en && $urandom_range(0, 2) == 0) begin
            t.we   = 1'($urandom_range(0, 1));
            t.addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            t.data = $urandom;
            load_port(i, p, t);
          end
        end
      end
    end

    if (was_idle && (req[i][0] || req[i][1])) begin
      if (req[i][0] && req[i][1]) win = ~mown[i];
      else                        win = req[i][1];
      t_we   = we[i][win];
      t_addr = addr[i][win];
      t_data = wdata[i][win];
      g_cyc  = cyc;
      a_cyc  = cyc + (t_we ? 2 : 2 + lat[i]);
      active = 1'b1;
      grants.push_back(int'(win));
      if (t_we) shadow[i][t_addr[5:2]] = t_data;
    end
  endtask

  task automatic drain(input int i, input int budget);
    int n = 0;
    while ((active || req[i] != 2'b00 || plan0.size() > 0 || plan1.size() > 0) && n < budget) begin
      step(i);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) shadow[i][k] = 32'hA5A5_0000 | 32'(k);
    #12 rst_n = 1'b1;

    // reset state on every instance
    step(0);
    step(1);
    step(2);

    // reset during a LATENCY=3 read
    plan0.push_back('{1'b0, 32'h0000_000C, 32'h0});
    n = 0;
    do begin
      step(0);
      n++;
    end while (!(active && cyc == g_cyc + 2) && n < 20);
    chk("reached_wait", 32'(active && cyc == g_cyc + 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",   busy[0],     32'd0);
    chk("rst_ack0",   ack[0][0],   32'd0);
    chk("rst_rdata0", rdata[0][0], 32'd0);
    chk("rst_mem_en", mem_en[0],   32'd0);
    chk("rst_owner",  owner[0],    32'd1);
    chk("rst_maddr",  mem_addr[0], 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain(0, 30);

    // port 0 write then port 1 read, LATENCY=1
    plan0.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
    drain(1, 20);
    plan1.push_back('{1'b0, 32'h0000_0010, 32'h0});
    drain(1, 20);
    chk("p1_read_data", rdata[1][1], 32'hDEAD_BEEF);
    chk("p0_untouched", rdata[1][0], 32'd0);
    chk("p1_owner",     owner[1],    32'd1);

    // simultaneous first requests, both reads, LATENCY=4
    grants.delete();
    plan0.push_back('{1'b0, 32'h0000_0004, 32'h0});
    plan1.push_back('{1'b0, 32'h0000_0008, 32'h0});
    drain(2, 40);
    chk("sim_count", grants.size(), 32'd2);
    for (int k = 0; k < grants.size(); k++) chk("sim_order", grants[k], 32'(k % 2));

    // LATENCY=4 read of freshly written data: one strobe for the read
    plan1.push_back('{1'b1, 32'h0000_0018, 32'h1234_5678});
    drain(2, 20);
    en_count = 0;
    plan0.push_back('{1'b0, 32'h0000_0018, 32'h0});
    drain(2, 20);
    chk("l4_strobes", en_count, 32'd1);
    chk("l4_rdata",   rdata[2][0], 32'h1234_5678);

    // continuous contention, 6 transactions
    grants.delete();
    for (int k = 0; k < 3; k++) begin
      plan0.push_back('{1'b0, {26'd0, 4'(k), 2'b00}, 32'h0});
      plan1.push_back('{1'b1, {26'd0, 4'(k + 8), 2'b00}, 32'hC0DE_0000 | 32'(k)});
    end
    drain(1, 100);
    chk("cont_count", grants.size(), 32'd6);
    for (int k = 0; k < grants.size(); k++) chk("cont_order", grants[k], 32'(k % 2));

    // randomized traffic on every instance
    for (int i = 0; i < 3; i++) begin
      rnd_en = 1'b1;
      repeat (400) step(i);
      rnd_en = 1'b0;
      drain(i, 60);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares one single-port, fixed-latency data memory between the CPU load/store port (port 0) and a second bus master such as a DMA or debug loader (port 1). It accepts one request at a time from each port, grants in round-robin order, and sequences the memory through issue, wait and completion. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the CPU/DMA memory interfaces and the data RAM.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LATENCY`, 1: memory read latency in cycles, legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  port 0 request; held high with fields stable until `m0_ack`.
- `m0_we`  in  1  port 0 write enable: 1 = write, 0 = read.
- `m0_addr`  in  AW  port 0 address.
- `m0_wdata`  in  DW  port 0 write data.
- `m0_ack`  out  1  port 0 completion pulse, one cycle.
- `m0_rdata`  out  DW  port 0 read data, registered.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: port 1, identical to port 0.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid `LATENCY` cycles after the `mem_en` cycle.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  index of the port that owns the current or last transaction.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one `mN_req`: grant that port.
  - Both requesting: grant the port that is not `owner`, i.e. alternate.
  - On grant: latch port index into `owner`, and latch `we`, `addr` and `wdata` into internal registers. Next state is ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_en` = 1, `mem_we` = latched `we`.
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - Next state is DONE for a write, WAIT for a read.
  - Load the wait counter with `LATENCY`.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter reaches 1, capture `mem_rdata` into the `m<owner>_rdata` register at that edge. Next state is DONE.
- **DONE** (exactly one cycle)
  - `m<owner>_ack` = 1. Next state is IDLE.
- Requesters drop `req` in the cycle after `ack`.
  - If a port's `req` is still high in the following IDLE cycle, it is a new transaction.
- The other port's `rdata` is never modified by a transaction it does not own.
- Outside ISSUE: `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last latched values.
- Request inputs are ignored in ISSUE, WAIT and DONE. The arbiter does not preempt a transaction in progress.
- The counter is 4 bits wide. `LATENCY` outside 1..15 is unsupported.

## Timing
- Reset values:
  - State IDLE.
  - `owner` = 1, so port 0 wins the first tie.
  - `m0_ack`, `m1_ack`, `mem_en`, `mem_we`, `busy` = 0.
  - `m0_rdata`, `m1_rdata`, `mem_addr`, `mem_wdata` = 0.
  - Counter = 0.
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - The in-flight transaction is abandoned with no `ack`, and `rdata` is not updated.
  - After reset is deasserted, a still-high `req` is treated as a fresh request.
- Cycle numbering: cycle 0 is IDLE with `req` high.
  - Write: ISSUE in cycle 1, DONE/`ack` in cycle 2. Latency is 2 cycles from request to ack, 3 cycles per transaction including the return to IDLE.
  - Read: ISSUE in cycle 1, WAIT in cycles 2..1+`LATENCY`, `rdata` valid from cycle 2+`LATENCY`, `ack` in cycle 2+`LATENCY`.
- `mN_rdata` is valid in the `ack` cycle. It holds until that port's next read completes.
- `busy` = 1 from cycle 1 through the `ack` cycle inclusive.
- Both ports requesting continuously: grants alternate. Neither port waits more than one full transaction.

## Test plan
- **Reset mid-read:** Read issued with `LATENCY`=3. Assert `rst` low in the WAIT state. Required: no `ack`, `rdata` unchanged at 0, `busy` = 0 immediately, and the next request is serviced normally.
- **Port 0 write:** Port 0 alone writes 0xDEADBEEF to address 0x10.
  - Required: `mem_en`/`mem_we` high only in cycle 1 with `mem_addr` = 0x10 and `mem_wdata` = 0xDEADBEEF.
  - `m0_ack` pulses in cycle 2; `busy` is high in cycles 1–2.
- **Port 1 read, LATENCY=1:** Port 1 alone reads address 0x10 with `LATENCY`=1; memory model returns 0xDEADBEEF.
  - Required: `m1_ack` in cycle 3 with `m1_rdata` = 0xDEADBEEF.
  - `m0_rdata` stays 0 and `owner` = 1.
- **Read, LATENCY=4:** Read with `LATENCY`=4. Required: `ack` in cycle 6, and exactly one `mem_en` pulse.
- **Simultaneous first requests:** Both ports raise `req` at the same time right after reset, both reading, each dropping `req` after its `ack`. Required: port 0 is served first, then port 1, with no overlap of `busy` periods.
- **Continuous contention:** Both ports hold `req` high for 6 back-to-back transactions. Required: grant order 0,1,0,1,0,1 and exactly one `ack` per transaction.
